// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status register.
// Define PARITY_EN to insert an even-parity bit between D7 and STOP (STATUS bit4 then reads 1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        sel,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef PARITY_EN
  localparam logic PAR_PRESENT = 1'b1;
`else
  localparam logic PAR_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_nx, ovf, full, empty, busy;
  logic          push, accept, pop, ovf_clr, bit_end;
  logic          unused_bits;

  assign sel     = (a[31:3] == BASE_ADDR[31:3]);
  assign push    = we & sel & ~a[2];
  assign ovf_clr = we & sel & a[2] & wd[3];
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != S_IDLE);
  // Full is sampled before the FSM pop, so a push while full drops even if a pop happens this edge.
  assign accept  = push & ~full;
  assign pop     = (state == S_IDLE) & ~empty;
  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  assign rd = (sel & a[2]) ? {27'b0, PAR_PRESENT, ovf, empty, full, busy} : 32'b0;
  assign unused_bits = ^{a[1:0], wd[31:8]};

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full)  ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
      tx    <= tx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!empty) state_nx = S_START;
      S_START:  if (bit_end) state_nx = S_DATA;
`ifdef PARITY_EN
      S_DATA:   if (bit_end && idx == 3'd7) state_nx = S_PARITY;
`else
      S_DATA:   if (bit_end && idx == 3'd7) state_nx = S_STOP;
`endif
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP:   if (bit_end) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // tx is registered, so it is derived from the state/bit being entered on this edge.
  always_comb begin
    cnt_nx   = (state == S_IDLE || bit_end) ? '0 : cnt + 1'b1;
    idx_nx   = idx;
    if (state == S_START) idx_nx = 3'd0;
    else if (state == S_DATA && bit_end) idx_nx = idx + 1'b1;
    shift_nx = pop ? mem[rptr] : shift;
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[idx_nx];
      S_PARITY: tx_nx = ^shift_nx;
      default:  tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Build with PARITY_EN defined to exercise the parity frame.
module tb_mmio_uart_tx;

  localparam int C = 4;
`ifdef PARITY_EN
  localparam int          NB = 11;
  localparam logic [31:0] PB = 32'h10;
`else
  localparam int          NB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = 32'h404;
  logic [31:0] wd = 32'h0;
  logic        sel;
  logic [31:0] rd;
  logic        tx;

  mmio_uart_tx #(.BASE_ADDR(32'h400), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .sel(sel), .rd(rd), .tx(tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Background frame decoder: samples each bit in its middle, records byte, parity, stop, start time.
  logic       mon_en = 1'b0;
  logic [7:0] mb;
  logic       mp;
  logic [7:0] rx_q[$];
  logic       par_q[$];
  logic       stop_q[$];
  int         st_q[$];

  always begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      st_q.push_back(cyc);
      repeat (C/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        mb[i] = tx;
      end
      mp = 1'b0;
`ifdef PARITY_EN
      repeat (C) @(negedge clk);
      mp = tx;
`endif
      repeat (C) @(negedge clk);
      rx_q.push_back(mb);
      par_q.push_back(mp);
      stop_q.push_back(tx);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0; a = 32'h404; wd = 32'h0;
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (rx_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("frames_received", rx_q.size(), n);
  endtask

  task automatic clear_mon();
    rx_q.delete(); par_q.delete(); stop_q.delete(); st_q.delete();
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (NB == 11 && j == 9) return ^d;
    return 1'b1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_tx", tx, 1);
    chk("rst_status", rd, 32'h4 | PB);
    chk("rst_sel", sel, 1);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single byte 0xA5, cycle-exact frame
    store(32'h400, 32'hA5); #1;
    chk("t2_pre_pop_status", rd, PB);
    for (int j = 0; j < NB; j++) begin
      for (int k = 0; k < C; k++) begin
        @(negedge clk); #1;
        chk($sformatf("t2_tx_bit%0d", j), tx, frame_bit(8'hA5, j));
        chk("t2_status_busy_empty", rd, 32'h5 | PB);
      end
    end
    @(negedge clk); #1;
    chk("t2_idle_tx", tx, 1);
    chk("t2_idle_status", rd, 32'h4 | PB);
    wait_frames(1, 20);
    chk("t2_rx_byte", rx_at(0), 8'hA5);

    // Fill FIFO, overflow, in-order frames with 1-cycle gaps
    repeat (3) @(negedge clk);
    clear_mon();
    for (int i = 0; i < 5; i++) store(32'h400, 32'h11 + i);
    #1;
    chk("t3_full_status", rd, 32'h3 | PB);
    store(32'h400, 32'h16); #1;
    chk("t3_ovf_status", rd, 32'hB | PB);
    a = 32'h400; #1;
    chk("t3_txdata_read", rd, 0);
    chk("t3_txdata_sel", sel, 1);
    a = 32'h404;
    wait_frames(5, 5 * NB * C + 50);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_byte%0d", i), rx_at(i), 8'h11 + i);
      chk($sformatf("t3_stop%0d", i), (i < stop_q.size()) ? stop_q[i] : 1'bx, 1);
    end
    for (int i = 1; i < 5 && i < st_q.size(); i++)
      chk($sformatf("t3_gap%0d", i), st_q[i] - st_q[i-1], NB * C + 1);
    repeat (10) @(negedge clk); #1;
    chk("t3_idle_ovf_status", rd, 32'hC | PB);

    // Overflow clear; miss address has no effect
    we = 1'b1; a = 32'h408; wd = 32'h8; #1;
    chk("t4_miss_sel", sel, 0);
    chk("t4_miss_rd", rd, 0);
    @(negedge clk);
    we = 1'b0; a = 32'h404; wd = 32'h0; #1;
    chk("t4_after_miss_status", rd, 32'hC | PB);
    store(32'h404, 32'h8); #1;
    chk("t4_ovf_cleared", rd, 32'h4 | PB);

    // Two queued bytes back to back
    clear_mon();
    store(32'h400, 32'h3C);
    store(32'h400, 32'hC3); #1;
    chk("t5_status_busy", rd, 32'h1 | PB);
    repeat (20) @(negedge clk); #1;
    chk("t5_busy_mid", rd[0], 1);
    wait_frames(2, 2 * NB * C + 50);
    chk("t5_byte0", rx_at(0), 8'h3C);
    chk("t5_byte1", rx_at(1), 8'hC3);
    if (st_q.size() >= 2) chk("t5_gap", st_q[1] - st_q[0], NB * C + 1);

`ifdef PARITY_EN
    repeat (10) @(negedge clk);
    clear_mon();
    store(32'h400, 32'h07);
    wait_frames(1, NB * C + 50);
    chk("t6_byte", rx_at(0), 8'h07);
    chk("t6_parity", (par_q.size() > 0) ? par_q[0] : 1'bx, 1);
    #1;
    chk("t6_status_bit4", rd[4], 1);
`endif

    // Reset mid-frame drops frame and queued bytes
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    store(32'h400, 32'h5A);
    store(32'h400, 32'h77);
    store(32'h400, 32'h66); #1;
    chk("t1_pre_reset_tx", tx, 0);
    reset = 1'b1; #1;
    chk("t1_reset_tx", tx, 1);
    chk("t1_reset_status", rd, 32'h4 | PB);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 3 * NB * C; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("t1_no_tx_after_reset", lows, 0);
    #1;
    chk("t1_final_status", rd, 32'h4 | PB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
